vga_fb_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM between the VGA scan-out fetcher (display

---
 rtl/vga_fb_arbiter_if.sv | 40 ++++
 rtl/vga_fb_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: display read port, draw read/write port and the
// single-port RAM pins, grouped so the arbiter and its neighbours share one bundle.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              drw_req;
  logic              drw_we;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] drw_wdata;
  logic              drw_gnt;
  logic              drw_rvalid;
  logic [DATA_W-1:0] drw_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  disp_req, disp_addr, drw_req, drw_we, drw_addr, drw_wdata, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, drw_gnt, drw_rvalid, drw_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / RAM side
  modport master (
    output disp_req, disp_addr, drw_req, drw_we, drw_addr, drw_wdata, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, drw_gnt, drw_rvalid, drw_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter. Display scan-out has priority; a starvation
// guard forces one draw slot after MAX_STARVE consecutive denied draw cycles.
// Commands are registered onto the RAM pins; a tag pipeline steers read-valid
// pulses back to the issuing port in grant order.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int MAX_STARVE = 8
) (
  input  logic             clk,
  input  logic             rst,
  vga_fb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);
  localparam int TAG_D = RD_LAT + 1;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              disp_gnt_s, drw_gnt_s;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Tag pipeline: valid marks a read grant, owner 1 = draw port.
  logic [TAG_D-1:0]  tag_vld_q, tag_own_q;

  // Grant selection, starve counter update and state transition.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    disp_gnt_s = 1'b0;
    drw_gnt_s  = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (bus.disp_req) begin
          disp_gnt_s = 1'b1;
        end else begin
          drw_gnt_s = bus.drw_req;
        end
      end
      ST_FORCE: begin
        drw_gnt_s = bus.drw_req;
      end
      default: begin
        disp_gnt_s = 1'b0;
        drw_gnt_s  = 1'b0;
      end
    endcase

    if (bus.drw_req && !drw_gnt_s) begin
      if (starve_q < CNT_W'(MAX_STARVE)) begin
        starve_d = starve_q + CNT_W'(1);
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = '0;
    end

    // The forced slot lasts one cycle; the grant in it clears the counter.
    if ((state_q == ST_NORMAL) && (starve_d == CNT_W'(MAX_STARVE))) begin
      state_d = ST_FORCE;
    end else begin
      state_d = ST_NORMAL;
    end
  end

  // Arbitration state and starve counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Register the granted command onto the RAM pins; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= disp_gnt_s | drw_gnt_s;
      mem_we_q <= drw_gnt_s & bus.drw_we;
      if (disp_gnt_s) begin
        mem_addr_q <= bus.disp_addr;
      end else if (drw_gnt_s) begin
        mem_addr_q  <= bus.drw_addr;
        mem_wdata_q <= bus.drw_wdata;
      end else begin
        mem_addr_q  <= mem_addr_q;
        mem_wdata_q <= mem_wdata_q;
      end
    end
  end

  // Shift read tags so each pulse lands when the RAM returns that read's data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[TAG_D-2:0], disp_gnt_s | (drw_gnt_s & ~bus.drw_we)};
      tag_own_q <= {tag_own_q[TAG_D-2:0], drw_gnt_s};
    end
  end

  assign bus.disp_gnt    = disp_gnt_s;
  assign bus.drw_gnt     = drw_gnt_s;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = tag_vld_q[TAG_D-1] & ~tag_own_q[TAG_D-1];
  assign bus.drw_rvalid  = tag_vld_q[TAG_D-1] &  tag_own_q[TAG_D-1];
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.drw_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level reference model (grant rules, command echo, read queue).
module tb_vga_fb_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 2;
  localparam int MAX_STARVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up content of the RAM (addr 5 holds 0x3C).
  function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
    logic [7:0] t;
    t = a[7:0];
    return t * 8'd7 + 8'h19;
  endfunction

  // ---------------- RAM environment model ----------------
  logic [7:0] ram_mem [1024];
  bit         ram_wr  [1024];
  logic [7:0] rd_pipe [RD_LAT];

  function automatic logic [7:0] ram_rd(input logic [ADDR_W-1:0] a);
    return ram_wr[a[9:0]] ? ram_mem[a[9:0]] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        ram_wr[bus.mem_addr[9:0]]  <= 1'b1;
      end
      rd_pipe[0] <= ram_rd(bus.mem_addr);
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- Reference model ----------------
  typedef struct {
    int         due;
    bit         own;
    logic [7:0] data;
  } rd_t;
  rd_t q[$];

  logic [7:0]        m_mem [1024];
  bit                m_wr  [1024];
  int                m_cyc  = 0;
  int                m_deny = 0;
  bit                m_en   = 1'b0;
  bit                m_we   = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_wd   = '0;
  bit                e_disp, e_drw;

  function automatic logic [7:0] m_rd(input logic [ADDR_W-1:0] a);
    return m_wr[a[9:0]] ? m_mem[a[9:0]] : init_byte(a);
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_disp_gnt", bus.disp_gnt, 0);
        chk("rst_drw_gnt", bus.drw_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_disp_rvalid", bus.disp_rvalid, 0);
        chk("rst_drw_rvalid", bus.drw_rvalid, 0);
        q.delete();
        m_deny = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
      end else begin
        // A draw slot is forced once the run of denied draw cycles hits the limit.
        if (m_deny == MAX_STARVE) begin
          e_disp = 1'b0;
          e_drw  = bus.drw_req;
        end else begin
          e_disp = bus.disp_req;
          e_drw  = bus.drw_req && !bus.disp_req;
        end
        chk("disp_gnt", bus.disp_gnt, e_disp);
        chk("drw_gnt", bus.drw_gnt, e_drw);
        chk("mem_en", bus.mem_en, m_en);
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wd);

        if (q.size() > 0 && q[0].due == m_cyc) begin
          chk("disp_rvalid", bus.disp_rvalid, !q[0].own);
          chk("drw_rvalid", bus.drw_rvalid, q[0].own);
          chk(q[0].own ? "drw_rdata" : "disp_rdata",
              q[0].own ? bus.drw_rdata : bus.disp_rdata, q[0].data);
          void'(q.pop_front());
        end else begin
          chk("disp_rvalid_idle", bus.disp_rvalid, 0);
          chk("drw_rvalid_idle", bus.drw_rvalid, 0);
        end

        // Advance the model by one grant decision.
        m_en = e_disp || e_drw;
        m_we = e_drw && bus.drw_we;
        if (e_disp) begin
          m_addr = bus.disp_addr;
          q.push_back('{m_cyc + 1 + RD_LAT, 1'b0, m_rd(bus.disp_addr)});
        end
        if (e_drw) begin
          m_addr = bus.drw_addr;
          m_wd   = bus.drw_wdata;
          if (bus.drw_we) begin
            m_mem[bus.drw_addr[9:0]] = bus.drw_wdata;
            m_wr[bus.drw_addr[9:0]]  = 1'b1;
          end else begin
            q.push_back('{m_cyc + 1 + RD_LAT, 1'b1, m_rd(bus.drw_addr)});
          end
        end
        if (bus.drw_req && !e_drw) m_deny = (m_deny < MAX_STARVE) ? m_deny + 1 : m_deny;
        else m_deny = 0;
      end
      m_cyc++;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.disp_req = 1'b0;
    bus.drw_req  = 1'b0;
    repeat (n) step();
  endtask

  task automatic starve_run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.disp_req = 1'b1; bus.disp_addr = 19'h00077;
      bus.drw_req  = 1'b1; bus.drw_we = 1'b0; bus.drw_addr = 19'h00040;
      #1;
      chk("starve_disp_gnt", bus.disp_gnt, (i % 9) != 8);
      chk("starve_drw_gnt", bus.drw_gnt, (i % 9) == 8);
    end
    idle(6);
  endtask

  bit g_disp, g_drw;

  initial begin : stim
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.drw_req = 1'b0; bus.drw_we = 1'b0; bus.drw_addr = '0; bus.drw_wdata = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    idle(2);

    // Priority, then draw write echo.
    step();
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00010;
    bus.drw_req = 1'b1; bus.drw_we = 1'b0; bus.drw_addr = 19'h00020;
    #1;
    chk("prio_disp_gnt", bus.disp_gnt, 1);
    chk("prio_drw_gnt", bus.drw_gnt, 0);
    step();
    bus.disp_req = 1'b0;
    #1;
    chk("prio_drw_next", bus.drw_gnt, 1);
    chk("prio_mem_en", bus.mem_en, 1);
    chk("prio_mem_we", bus.mem_we, 0);
    chk("prio_mem_addr", bus.mem_addr, 19'h00010);
    step();
    bus.drw_we = 1'b1; bus.drw_addr = 19'h12345; bus.drw_wdata = 8'hA5;
    #1;
    chk("wr_drw_gnt", bus.drw_gnt, 1);
    step();
    bus.drw_req = 1'b0;
    #1;
    chk("wr_mem_en", bus.mem_en, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 19'h12345);
    chk("wr_mem_wdata", bus.mem_wdata, 8'hA5);

    // Read latency: display read of addr 5.
    step();
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00005;
    #1;
    chk("lat_disp_gnt", bus.disp_gnt, 1);
    step();
    bus.disp_req = 1'b0;
    step();
    chk("lat_rvalid_early", bus.disp_rvalid, 0);
    step();
    chk("lat_disp_rvalid", bus.disp_rvalid, 1);
    chk("lat_disp_rdata", bus.disp_rdata, 8'h3C);
    chk("lat_drw_rvalid", bus.drw_rvalid, 0);
    step();
    chk("lat_rvalid_late", bus.disp_rvalid, 0);
    idle(3);

    // Starvation pattern: 8 display, 1 draw, repeating.
    starve_run(27);

    // Interleaved reads.
    for (int i = 0; i < 20; i++) begin
      step();
      bus.disp_req = (i % 2) == 0; bus.disp_addr = ADDR_W'(32'h100 + i);
      bus.drw_req = (i % 2) == 1; bus.drw_we = 1'b0; bus.drw_addr = ADDR_W'(32'h200 + i);
      #1;
      chk("ilv_gnt", (i % 2) == 0 ? bus.disp_gnt : bus.drw_gnt, 1);
    end
    idle(6);

    // Draw write then read of the same address.
    step();
    bus.drw_req = 1'b1; bus.drw_we = 1'b1; bus.drw_addr = 19'h00033; bus.drw_wdata = 8'h5E;
    step();
    bus.drw_we = 1'b0;
    step();
    bus.drw_req = 1'b0;
    step();
    step();
    chk("raw_drw_rvalid", bus.drw_rvalid, 1);
    chk("raw_drw_rdata", bus.drw_rdata, 8'h5E);
    idle(4);

    // Reset with two reads outstanding.
    step();
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00010;
    step();
    bus.disp_req = 1'b0;
    bus.drw_req = 1'b1; bus.drw_we = 1'b0; bus.drw_addr = 19'h00011;
    step();
    bus.drw_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_en", bus.mem_en, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_disp_rvalid", bus.disp_rvalid, 0);
    chk("arst_drw_rvalid", bus.drw_rvalid, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_disp_rvalid", bus.disp_rvalid, 0);
      chk("post_rst_drw_rvalid", bus.drw_rvalid, 0);
    end
    starve_run(18);

    // Randomized traffic; requests hold until granted.
    g_disp = 1'b0;
    g_drw  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!bus.disp_req || g_disp) begin
        bus.disp_req  = $urandom_range(0, 3) != 0;
        bus.disp_addr = ADDR_W'($urandom_range(0, 63));
      end
      if (!bus.drw_req || g_drw) begin
        bus.drw_req   = $urandom_range(0, 2) != 0;
        bus.drw_we    = 1'($urandom_range(0, 1));
        bus.drw_addr  = ADDR_W'($urandom_range(0, 63));
        bus.drw_wdata = 8'($urandom);
      end
      #2;
      g_disp = bus.disp_gnt;
      g_drw  = bus.drw_gnt;
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
